// File: rtl/uart_defs.sv
// Shared UART definitions: instruction opcodes and the receive FSM state encoding.
package uart_defs;

    localparam logic [5:0] OPCODE_SND = 6'b010001;
    localparam logic [5:0] OPCODE_RCV = 6'b010010;

    // Value written to the register file when a receive ends by timeout.
    localparam logic [31:0] RCV_TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } rcv_state_e;

endpackage

// File: rtl/rcv_watchdog.sv
// Counts consecutive cycles with enable high; expired flags the last allowed cycle.
module rcv_watchdog #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic expired
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Count while enabled, restart from zero as soon as enable drops.
    always_comb begin
        count_d = enable ? count_q + 16'd1 : 16'd0;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) count_q <= 16'd0;
        else       count_q <= count_d;
    end

    assign expired = enable && (count_q == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/receive_control.sv
// Receive-instruction controller: stalls the CPU on RCV until the UART receiver
// offers a byte, acknowledges it once and writes it zero-extended to the register file.
// Optional timeout watchdog is compiled in when RCV_TIMEOUT_EN is defined.
module receive_control #(
    parameter logic [5:0]  OPCODE_RCV     = uart_defs::OPCODE_RCV,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    output logic [31:0] rcv_data,
    output logic        rcv_write,
    output logic        rcv_stall,
    output logic        rcv_timeout
);

    import uart_defs::*;

    rcv_state_e  state_q, state_d;
    logic [31:0] rcv_data_q, rcv_data_d;
    logic        opcode_match;
    logic        timeout_hit;

    assign opcode_match = (opcode == OPCODE_RCV);

`ifdef RCV_TIMEOUT_EN
    logic wd_expired;
    logic rcv_timeout_q, rcv_timeout_d;

    rcv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .enable  (state_q == ST_WAIT),
        .expired (wd_expired)
    );

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_hit = wd_expired && !rx_valid;

    // Timeout flag: set by a timeout capture, cleared by the next real capture.
    always_comb begin
        rcv_timeout_d = rcv_timeout_q;
        if (state_q == ST_WAIT) begin
            if (rx_valid)         rcv_timeout_d = 1'b0;
            else if (timeout_hit) rcv_timeout_d = 1'b1;
        end
    end

    // Timeout flag register.
    always_ff @(posedge clock) begin
        if (reset) rcv_timeout_q <= 1'b0;
        else       rcv_timeout_q <= rcv_timeout_d;
    end

    assign rcv_timeout = rcv_timeout_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
    assign rcv_timeout           = 1'b0;
`endif

    // Next-state and capture-data logic of the receive FSM.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d    = state_q;
        rcv_data_d = rcv_data_q;
        case (state_q)
            ST_IDLE: begin
                if (opcode_match) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rx_valid) begin
                    state_d    = ST_CAPTURE;
                    rcv_data_d = {24'd0, rx_data};
                end else if (timeout_hit) begin
                    state_d    = ST_CAPTURE;
                    rcv_data_d = RCV_TIMEOUT_DATA;
                end
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM state and captured-data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rcv_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            rcv_data_q <= rcv_data_d;
        end
    end

    // Strobes are forced low while reset is asserted, whatever the opcode.
    assign rcv_stall = !reset && ((state_q == ST_IDLE && opcode_match) || state_q == ST_WAIT);
    assign rx_ack    = !reset && (state_q == ST_WAIT) && rx_valid;
    assign rcv_write = !reset && (state_q == ST_CAPTURE);
    assign rcv_data  = rcv_data_q;

endmodule

// File: tb/tb_receive_control.sv
// Self-checking bench for receive_control: per-cycle strobe checks plus a
// scoreboard of expected register-file writes.
module tb_receive_control;

    import uart_defs::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ack;
    logic [31:0] rcv_data;
    logic        rcv_write;
    logic        rcv_stall;
    logic        rcv_timeout;

    int n_compared   = 0;
    int n_mismatched = 0;
    int ack_count    = 0;
    int exp_acks     = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    receive_control #(
        .OPCODE_RCV     (6'b010010),
        .TIMEOUT_CYCLES (16'd50000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ack      (rx_ack),
        .rcv_data    (rcv_data),
        .rcv_write   (rcv_write),
        .rcv_stall   (rcv_stall),
        .rcv_timeout (rcv_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe pops the next expected byte.
    always @(negedge clock) begin
        if (rx_ack === 1'b1) ack_count++;
        if (rcv_write === 1'b1) begin
            if (exp_q.size() == 0) check("write_unexpected", 32'd1, 32'd0);
            else                   check("rcv_data", rcv_data, exp_q.pop_front());
        end
    end

    // Drive one cycle of inputs, check the strobes mid-cycle, advance past the edge.
    task automatic step(input string tag, input logic [5:0] op, input logic v,
                        input logic [7:0] d, input logic s, input logic a, input logic w);
        opcode   = op;
        rx_valid = v;
        rx_data  = d;
        @(negedge clock);
        check({tag, ".stall"}, 32'(rcv_stall), 32'(s));
        check({tag, ".ack"},   32'(rx_ack),    32'(a));
        check({tag, ".write"}, 32'(rcv_write), 32'(w));
        @(posedge clock);
        #1;
    endtask

`ifdef RCV_TIMEOUT_EN
    logic [5:0]  to_opcode;
    logic        to_rx_valid;
    logic [7:0]  to_rx_data;
    logic        to_rx_ack, to_rcv_write, to_rcv_stall, to_rcv_timeout;
    logic [31:0] to_rcv_data;

    receive_control #(
        .OPCODE_RCV     (6'b010010),
        .TIMEOUT_CYCLES (16'd8)
    ) dut_to (
        .clock       (clock),
        .reset       (reset),
        .opcode      (to_opcode),
        .rx_valid    (to_rx_valid),
        .rx_data     (to_rx_data),
        .rx_ack      (to_rx_ack),
        .rcv_data    (to_rcv_data),
        .rcv_write   (to_rcv_write),
        .rcv_stall   (to_rcv_stall),
        .rcv_timeout (to_rcv_timeout)
    );

    task automatic to_step(input string tag, input logic [5:0] op, input logic v,
                           input logic [7:0] d, input logic s, input logic a, input logic w);
        to_opcode   = op;
        to_rx_valid = v;
        to_rx_data  = d;
        @(negedge clock);
        check({tag, ".stall"}, 32'(to_rcv_stall), 32'(s));
        check({tag, ".ack"},   32'(to_rx_ack),    32'(a));
        check({tag, ".write"}, 32'(to_rcv_write), 32'(w));
        @(posedge clock);
        #1;
    endtask
`endif

    // Hard bound on simulated time.
    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
`ifdef RCV_TIMEOUT_EN
        to_opcode = 6'd0; to_rx_valid = 1'b0; to_rx_data = 8'h00;
`endif
        // Reset: strobes held low even with a matching opcode and a byte waiting.
        reset = 1'b1;
        step("rst0", OPCODE_RCV, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step("rst1", OPCODE_RCV, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check("rst.rcv_data",    rcv_data,            32'd0);
        check("rst.rcv_timeout", 32'(rcv_timeout),    32'd0);
        reset = 1'b0;
        step("idle", 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Byte already waiting: stall N,N+1; ack N+1; write N+2.
        exp_q.push_back(32'h0000_0041);
        step("t1c0", OPCODE_RCV, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
        step("t1c1", OPCODE_RCV, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0);
        exp_acks++;
        step("t1c2", 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step("t1c3", 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t1.hold", rcv_data, 32'h0000_0041);

        // Byte arrives 10 cycles after the RCV: 11 stall cycles, one ack.
        exp_q.push_back(32'h0000_00A5);
        step("t2c0", OPCODE_RCV, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++)
            step($sformatf("t2c%0d", i), OPCODE_RCV, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step("t2c10", OPCODE_RCV, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        exp_acks++;
        step("t2c11", 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Back-to-back RCVs; next byte offered during CAPTURE must be ignored.
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h0000_0002);
        step("t3c0", OPCODE_RCV, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        step("t3c1", OPCODE_RCV, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        step("t3c2", OPCODE_RCV, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        step("t3c3", OPCODE_RCV, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        step("t3c4", OPCODE_RCV, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
        exp_acks += 2;
        step("t3c5", 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Send opcode with a byte waiting: nothing happens.
        for (int i = 0; i < 3; i++)
            step($sformatf("t4c%0d", i), OPCODE_SND, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step("t4end", 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset in the 3rd WAIT cycle: no ack, no capture, back to IDLE.
        step("t5c0", OPCODE_RCV, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step("t5c1", OPCODE_RCV, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step("t5c2", OPCODE_RCV, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step("t5c3", OPCODE_RCV, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step("t5c4", 6'd0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step("t5c5", 6'd0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check("t5.rcv_data",    rcv_data,         32'd0);
        check("t5.rcv_timeout", 32'(rcv_timeout), 32'd0);
        step("t5end", 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef RCV_TIMEOUT_EN
        // Timeout with TIMEOUT_CYCLES=8: WAIT in cycles 1-8, timeout write in cycle 9.
        to_step("t6c0", OPCODE_RCV, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 9; i++)
            to_step($sformatf("t6c%0d", i), OPCODE_RCV, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        to_opcode = 6'd0;
        @(negedge clock);
        check("t6c9.write",   32'(to_rcv_write),   32'd1);
        check("t6c9.data",    to_rcv_data,         32'hFFFF_FFFF);
        check("t6c9.timeout", 32'(to_rcv_timeout), 32'd1);
        @(posedge clock);
        #1;
        // A following successful capture clears the flag.
        to_step("t7c0", OPCODE_RCV, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        to_step("t7c1", OPCODE_RCV, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
        to_opcode = 6'd0; to_rx_valid = 1'b0;
        @(negedge clock);
        check("t7c2.write",   32'(to_rcv_write),   32'd1);
        check("t7c2.data",    to_rcv_data,         32'h0000_003C);
        check("t7c2.timeout", 32'(to_rcv_timeout), 32'd0);
        @(posedge clock);
        #1;
`endif

        step("drain", 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("ack_total",   32'(ack_count),    32'(exp_acks));
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/receive_control.md
RECEIVE_CONTROL -- requirements
Module: receive_control

Interface
REQ-001 SHALL have parameter OPCODE_RCV, default 6'b010010, the receive-instruction opcode.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, the WAIT cycles before timeout (used only with RCV_TIMEOUT_EN).
REQ-003 SHALL have port clock  in  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port opcode  in  6  opcode of the current CPU instruction.
REQ-006 SHALL have port rx_valid  in  1  UART receiver byte ready; held high until acknowledged.
REQ-007 SHALL have port rx_data  in  8  received byte; stable while rx_valid is high.
REQ-008 SHALL have port rx_ack  out  1  one-cycle consume strobe to the UART receiver.
REQ-009 SHALL have port rcv_data  out  32  captured byte, zero-extended, to the register-file write port.
REQ-010 SHALL have port rcv_write  out  1  one-cycle register-file write strobe.
REQ-011 SHALL have port rcv_stall  out  1  holds the PC while a receive is pending.
REQ-012 SHALL have port rcv_timeout  out  1  set when the last receive ended by timeout; constant 0 without RCV_TIMEOUT_EN.

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT and CAPTURE.
REQ-014 SHALL transition IDLE->WAIT when opcode==OPCODE_RCV; otherwise SHALL remain in IDLE.
REQ-015 SHALL transition WAIT->CAPTURE on the edge where rx_valid=1, latching {24'b0, rx_data} into rcv_data.
REQ-016 SHALL transition CAPTURE->IDLE unconditionally after one cycle, so a back-to-back RCV is decoded as a new instruction.
REQ-017 SHALL drive rcv_stall = (IDLE and opcode match) or WAIT, combinationally; rcv_stall SHALL be 0 in CAPTURE.
REQ-018 SHALL drive rx_ack = WAIT and rx_valid; there SHALL be exactly one ack per instruction.
REQ-019 SHALL drive rcv_write = 1 only in CAPTURE; rcv_data SHALL hold its value until the next capture.
REQ-020 SHALL meet this latency for an opcode first present in cycle N with rx_valid already high: stall in N and N+1, ack in N+1, write in N+2.
REQ-021 SHALL ignore rx_valid while in IDLE or CAPTURE: no ack, and the byte stays in the receiver.
REQ-022 SHALL handle opcode match together with rx_valid=1 in the same IDLE cycle exactly as REQ-020, with no early ack.
REQ-023 SHALL NOT abort WAIT if opcode changes during it; the stall freezes the instruction, so this is a CPU fault and is not handled.

Reset
REQ-024 SHALL on reset=1 at a clock edge set state=IDLE, rcv_data=0, rcv_timeout=0 and the timeout counter=0, from any state.
REQ-025 SHALL drive rx_ack=0, rcv_write=0 and rcv_stall=0 while reset=1, regardless of opcode.
REQ-026 SHALL, when reset occurs mid-WAIT, perform no capture and issue no ack; any pending byte remains in the receiver.

Configuration
REQ-027 SHALL compile the timeout watchdog only when macro RCV_TIMEOUT_EN is defined.
REQ-028 SHALL, with RCV_TIMEOUT_EN defined, behave as follows:
- count cycles spent in WAIT;
- at count TIMEOUT_CYCLES-1 with rx_valid=0, go to CAPTURE with rcv_data=32'hFFFFFFFF and rcv_timeout=1;
- clear rcv_timeout on the next successful capture;
- give rx_valid=1 priority over timeout in the same cycle.
REQ-029 SHALL, without RCV_TIMEOUT_EN, wait in WAIT indefinitely and tie rcv_timeout to 0.

Structure
REQ-030 SHALL take the opcode constants (OPCODE_SND, OPCODE_RCV) and the FSM state encodings from the shared UART definitions package (uart_defs).
REQ-031 SHALL place the WAIT counter in one sub-module, rcv_watchdog (inputs clock, reset, enable; output expired), instantiated only under RCV_TIMEOUT_EN.

Verification
REQ-032 SHALL cover: opcode=6'b010010 at cycle 0 with rx_valid=1 and rx_data=8'h41 -> stall in cycles 0-1, ack in cycle 1, write in cycle 2 with rcv_data=32'h00000041.
REQ-033 SHALL cover: RCV issued, rx_valid raised 10 cycles later with 8'hA5 -> stall held for 11 cycles, one ack, rcv_data=32'h000000A5.
REQ-034 SHALL cover: two consecutive RCV instructions with bytes 8'h01 then 8'h02 -> two acks and two writes with data 1 then 2.
REQ-035 SHALL cover: rx_valid=1 with opcode=6'b010001 (send) -> no ack, no write, no stall.
REQ-036 SHALL cover: reset pulsed in the 3rd WAIT cycle -> IDLE next cycle, all outputs 0, rx_valid still pending.
REQ-037 SHALL cover, with RCV_TIMEOUT_EN and TIMEOUT_CYCLES=8: no rx_valid -> write in cycle 9 with rcv_data=32'hFFFFFFFF and rcv_timeout=1.
